// File: rtl/hazard_pkg.sv
// Shared types and constants for the ID-stage hazard control unit.
package hazard_pkg;

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      LOAD_STALL = 2'd1,
      FLUSH      = 2'd2
   } hz_state_e;

   localparam logic [1:0] J_NONE = 2'd0;
   localparam logic [1:0] J_J    = 2'd1;
   localparam logic [1:0] J_JR   = 2'd2;

   // Code 2'b11 is reserved and must not redirect fetch.
   function automatic logic is_redirect(input logic [1:0] jump, input logic pcsrc);
      logic jmp;
      case (jump)
         J_NONE:     jmp = 1'b0;
         J_J, J_JR:  jmp = 1'b1;
         default:    jmp = 1'b0;
      endcase
      return jmp || pcsrc;
   endfunction

endpackage

// File: rtl/hazard_control_unit_if.sv
// ID-stage hazard signals: decode/execute fields in, pipeline enables out.
interface hazard_control_unit_if #(
   parameter int REG_AW = 5
);
   logic [REG_AW-1:0] IFIDrs;
   logic [REG_AW-1:0] IFIDrt;
   logic              IFIDUsesRt;
   logic              IFIDUsesHiLo;
   logic [REG_AW-1:0] IDEXrt;
   logic              IDEXMemRead;
   logic              MDStart;
   logic [1:0]        Jump;
   logic              PCSrc;
   logic              Stall;
   logic              ControlZero;
   logic              FlushIFID;
   logic              MDBusy;

   modport master (
      output IFIDrs, IFIDrt, IFIDUsesRt, IFIDUsesHiLo, IDEXrt, IDEXMemRead,
             MDStart, Jump, PCSrc,
      input  Stall, ControlZero, FlushIFID, MDBusy
   );

   modport slave (
      input  IFIDrs, IFIDrt, IFIDUsesRt, IFIDUsesHiLo, IDEXrt, IDEXMemRead,
             MDStart, Jump, PCSrc,
      output Stall, ControlZero, FlushIFID, MDBusy
   );
endinterface

// File: rtl/stall_counter.sv
// Loadable down-counter that holds at zero instead of wrapping.
module stall_counter #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic [W-1:0] val,
   input  logic         dec,
   output logic [W-1:0] cnt,
   output logic         zero
);
   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = val;
      end else if (dec && (cnt_q != '0)) begin
         cnt_d = cnt_q - W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt  = cnt_q;
   assign zero = (cnt_q == '0);
endmodule

// File: rtl/hazard_control_unit.sv
// ID-stage hazard control: multi-cycle load-use stalls, mult/div HI/LO
// interlock and multi-cycle IF/ID flush after redirects.
module hazard_control_unit
   import hazard_pkg::*;
#(
   parameter int REG_AW       = 5,
   parameter int LOAD_LAT     = 1,
   parameter int MD_LAT       = 32,
   parameter int FLUSH_JUMP   = 1,
   parameter int FLUSH_BRANCH = 1
) (
   input  logic                  Clk,
   input  logic                  Rst_n,
   hazard_control_unit_if.slave  hif
);
   localparam logic [3:0] LD_RELOAD      = 4'(LOAD_LAT - 1);
   localparam logic [5:0] MD_RELOAD      = 6'(MD_LAT);
   localparam logic [1:0] FL_JUMP_RELOAD = 2'(FLUSH_JUMP - 1);
   localparam logic [1:0] FL_BR_RELOAD   = 2'(FLUSH_BRANCH - 1);

   hz_state_e         state_q;
   hz_state_e         state_d;
   logic [REG_AW-1:0] idex_rt;
   logic              lu_hit;
   logic              redirect;
   logic [1:0]        fl_reload;
   logic              fl_multi;

   logic       ld_load, ld_dec, ld_zero;
   logic [3:0] ld_val, ld_cnt;
   logic       fl_load, fl_dec, fl_zero;
   logic [1:0] fl_cnt;
   logic       md_zero;
   logic [5:0] md_cnt;

   logic flush, fsm_stall, md_busy, stall;

   assign idex_rt  = hif.IDEXrt;
   assign lu_hit   = hif.IDEXMemRead && (idex_rt != '0) &&
                     ((idex_rt == hif.IFIDrs) ||
                      (hif.IFIDUsesRt && (idex_rt == hif.IFIDrt)));
   assign redirect = is_redirect(hif.Jump, hif.PCSrc);
   // A taken branch decides the flush length when it coincides with a jump.
   assign fl_reload = hif.PCSrc ? FL_BR_RELOAD : FL_JUMP_RELOAD;
   assign fl_multi  = (fl_reload != 2'd0);

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      ld_load = 1'b0;
      ld_val  = LD_RELOAD;
      ld_dec  = 1'b0;
      fl_load = 1'b0;
      fl_dec  = 1'b0;
      case (state_q)
         IDLE: begin
            if (redirect) begin
               fl_load = 1'b1;
               state_d = fl_multi ? FLUSH : IDLE;
            end else if (lu_hit && (LOAD_LAT > 1)) begin
               ld_load = 1'b1;
               state_d = LOAD_STALL;
            end
         end
         LOAD_STALL: begin
            if (redirect) begin
               ld_load = 1'b1;
               ld_val  = '0;
               fl_load = 1'b1;
               state_d = fl_multi ? FLUSH : IDLE;
            end else begin
               ld_dec = 1'b1;
               if ((ld_cnt == 4'd1) || ld_zero) state_d = IDLE;
            end
         end
         FLUSH: begin
            if (redirect) begin
               fl_load = 1'b1;
               state_d = fl_multi ? FLUSH : IDLE;
            end else begin
               fl_dec = 1'b1;
               if ((fl_cnt == 2'd1) || fl_zero) state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Squashing the ID instruction makes any stall on it pointless.
   always_comb begin
      flush     = redirect || (state_q == FLUSH);
      fsm_stall = ((state_q == IDLE) && lu_hit) || (state_q == LOAD_STALL);
      md_busy   = !md_zero;
      stall     = !flush && (fsm_stall || (md_busy && hif.IFIDUsesHiLo));
   end

   assign hif.Stall       = Rst_n && stall;
   assign hif.ControlZero = Rst_n && stall;
   assign hif.FlushIFID   = Rst_n && flush;
   assign hif.MDBusy      = Rst_n && md_busy && (md_cnt != '0);

   stall_counter #(.W(4)) u_ld_cnt (
      .clk   (Clk),
      .rst_n (Rst_n),
      .load  (ld_load),
      .val   (ld_val),
      .dec   (ld_dec),
      .cnt   (ld_cnt),
      .zero  (ld_zero)
   );

   stall_counter #(.W(2)) u_fl_cnt (
      .clk   (Clk),
      .rst_n (Rst_n),
      .load  (fl_load),
      .val   (fl_reload),
      .dec   (fl_dec),
      .cnt   (fl_cnt),
      .zero  (fl_zero)
   );

   stall_counter #(.W(6)) u_md_cnt (
      .clk   (Clk),
      .rst_n (Rst_n),
      .load  (hif.MDStart),
      .val   (MD_RELOAD),
      .dec   (!md_zero),
      .cnt   (md_cnt),
      .zero  (md_zero)
   );
endmodule

// File: tb/tb_hazard_control_unit.sv
// Directed scoreboard bench for hazard_control_unit using two parameter sets.
module tb_hazard_control_unit;
   import hazard_pkg::*;

   typedef struct {
      string      tag;
      logic [3:0] ea;
      logic [3:0] eb;
   } exp_t;

   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_pass;
   exp_t sb[$];
   exp_t cur;

   hazard_control_unit_if #(.REG_AW(5)) ifa ();
   hazard_control_unit_if #(.REG_AW(5)) ifb ();

   // Unit A: single-bubble loads, long mult/div, one-cycle flushes.
   hazard_control_unit #(
      .REG_AW(5), .LOAD_LAT(1), .MD_LAT(32), .FLUSH_JUMP(1), .FLUSH_BRANCH(1)
   ) u_dut_a (
      .Clk   (clk),
      .Rst_n (rst_n),
      .hif   (ifa.slave)
   );

   // Unit B: three-bubble loads, short mult/div, two-cycle jump flush.
   hazard_control_unit #(
      .REG_AW(5), .LOAD_LAT(3), .MD_LAT(4), .FLUSH_JUMP(2), .FLUSH_BRANCH(1)
   ) u_dut_b (
      .Clk   (clk),
      .Rst_n (rst_n),
      .hif   (ifb.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [3:0] obs_a();
      return {ifa.Stall, ifa.ControlZero, ifa.FlushIFID, ifa.MDBusy};
   endfunction

   function automatic logic [3:0] obs_b();
      return {ifb.Stall, ifb.ControlZero, ifb.FlushIFID, ifb.MDBusy};
   endfunction

   task automatic drv(input logic [4:0] rs, input logic [4:0] rt, input logic urt,
                      input logic hilo, input logic [4:0] xrt, input logic mr,
                      input logic mds, input logic [1:0] j, input logic pc);
      ifa.IFIDrs = rs;  ifa.IFIDrt = rt;  ifa.IFIDUsesRt = urt; ifa.IFIDUsesHiLo = hilo;
      ifa.IDEXrt = xrt; ifa.IDEXMemRead = mr; ifa.MDStart = mds; ifa.Jump = j; ifa.PCSrc = pc;
      ifb.IFIDrs = rs;  ifb.IFIDrt = rt;  ifb.IFIDUsesRt = urt; ifb.IFIDUsesHiLo = hilo;
      ifb.IDEXrt = xrt; ifb.IDEXMemRead = mr; ifb.MDStart = mds; ifb.Jump = j; ifb.PCSrc = pc;
   endtask

   task automatic idle();
      drv(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, J_NONE, 1'b0);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Expected vectors are {Stall, ControlZero, FlushIFID, MDBusy}.
   task automatic push(input string tag, input logic [3:0] ea, input logic [3:0] eb);
      exp_t e;
      e.tag = tag;
      e.ea  = ea;
      e.eb  = eb;
      sb.push_back(e);
   endtask

   always @(negedge clk) begin
      if (sb.size() > 0) begin
         cur = sb.pop_front();
         n_checks++;
         assert (obs_a() === cur.ea) n_pass++;
         else $error("FAIL %s dutA observed %b expected %b", cur.tag, obs_a(), cur.ea);
         n_checks++;
         assert (obs_b() === cur.eb) n_pass++;
         else $error("FAIL %s dutB observed %b expected %b", cur.tag, obs_b(), cur.eb);
      end
   end

   initial begin
      n_checks = 0;
      n_pass   = 0;
      rst_n    = 1'b0;
      drv(5'd8, 5'd0, 1'b0, 1'b1, 5'd8, 1'b1, 1'b1, J_J, 1'b1);
      #2;
      n_checks++;
      assert (obs_a() === 4'b0000) n_pass++;
      else $error("FAIL reset_a observed %b expected %b", obs_a(), 4'b0000);
      n_checks++;
      assert (obs_b() === 4'b0000) n_pass++;
      else $error("FAIL reset_b observed %b expected %b", obs_b(), 4'b0000);

      @(posedge clk);
      #1;
      rst_n = 1'b1;
      idle();

      // Load-use on rs: A stalls once, B stalls three cycles.
      tick(); drv(5'd8, 5'd0, 1'b0, 1'b0, 5'd8, 1'b1, 1'b0, J_NONE, 1'b0); push("lu_c1", 4'b1100, 4'b1100);
      tick(); idle(); push("lu_c2", 4'b0000, 4'b1100);
      tick(); idle(); push("lu_c3", 4'b0000, 4'b1100);
      tick(); idle(); push("lu_done", 4'b0000, 4'b0000);
      tick(); drv(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, J_NONE, 1'b0); push("lu_r0", 4'b0000, 4'b0000);

      // Branch taken in B's second stall cycle aborts the stall.
      tick(); drv(5'd8, 5'd0, 1'b0, 1'b0, 5'd8, 1'b1, 1'b0, J_NONE, 1'b0); push("ab_c1", 4'b1100, 4'b1100);
      tick(); drv(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, J_NONE, 1'b1); push("ab_br", 4'b0010, 4'b0010);
      tick(); idle(); push("ab_idle", 4'b0000, 4'b0000);

      // jr with a coincident load-use: flush only, B flushes two cycles.
      tick(); drv(5'd8, 5'd0, 1'b0, 1'b0, 5'd8, 1'b1, 1'b0, J_JR, 1'b0); push("jr_c1", 4'b0010, 4'b0010);
      tick(); idle(); push("jr_c2", 4'b0000, 4'b0010);
      tick(); idle(); push("jr_done", 4'b0000, 4'b0000);
      tick(); drv(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 2'd3, 1'b0); push("j_rsvd", 4'b0000, 4'b0000);

      // j, then a load-use arriving while B is still flushing.
      tick(); drv(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, J_J, 1'b0); push("j_c1", 4'b0010, 4'b0010);
      tick(); drv(5'd8, 5'd0, 1'b0, 1'b0, 5'd8, 1'b1, 1'b0, J_NONE, 1'b0); push("j_c2_lu", 4'b1100, 4'b0010);
      tick(); idle(); push("j_done", 4'b0000, 4'b0000);

      // rt path only counts when the ID instruction reads rt.
      tick(); drv(5'd3, 5'd8, 1'b0, 1'b0, 5'd8, 1'b1, 1'b0, J_NONE, 1'b0); push("rt_unused", 4'b0000, 4'b0000);
      tick(); drv(5'd3, 5'd8, 1'b1, 1'b0, 5'd8, 1'b1, 1'b0, J_NONE, 1'b0); push("rt_c1", 4'b1100, 4'b1100);
      tick(); idle(); push("rt_c2", 4'b0000, 4'b1100);
      tick(); idle(); push("rt_c3", 4'b0000, 4'b1100);
      tick(); idle(); push("rt_done", 4'b0000, 4'b0000);

      // Mult/div issue, HI/LO reader waiting in ID.
      tick(); drv(5'd0, 5'd0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b1, J_NONE, 1'b0); push("md_issue", 4'b0000, 4'b0000);
      tick(); drv(5'd0, 5'd0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, J_NONE, 1'b0); push("md_b1", 4'b1101, 4'b1101);
      tick(); push("md_b2", 4'b1101, 4'b1101);
      tick(); push("md_b3", 4'b1101, 4'b1101);
      tick(); push("md_b4", 4'b1101, 4'b1101);
      tick(); push("md_b5", 4'b1101, 4'b0000);
      tick(); drv(5'd0, 5'd0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, J_NONE, 1'b1); push("md_redir", 4'b0011, 4'b0010);
      tick(); idle(); push("md_noread", 4'b0001, 4'b0000);

      // Enter B's LOAD_STALL, then reset asynchronously between edges.
      tick(); drv(5'd8, 5'd0, 1'b0, 1'b0, 5'd8, 1'b1, 1'b0, J_NONE, 1'b0); push("rs_c1", 4'b1101, 4'b1100);
      tick(); idle(); push("rs_c2", 4'b0001, 4'b1100);
      @(negedge clk);
      #2;
      drv(5'd8, 5'd0, 1'b0, 1'b1, 5'd8, 1'b1, 1'b0, J_NONE, 1'b0);
      rst_n = 1'b0;
      #1;
      n_checks++;
      assert (obs_a() === 4'b0000) n_pass++;
      else $error("FAIL midrst_a observed %b expected %b", obs_a(), 4'b0000);
      n_checks++;
      assert (obs_b() === 4'b0000) n_pass++;
      else $error("FAIL midrst_b observed %b expected %b", obs_b(), 4'b0000);

      tick(); rst_n = 1'b1; idle(); push("post_rst1", 4'b0000, 4'b0000);
      tick(); push("post_rst2", 4'b0000, 4'b0000);

      repeat (4) @(negedge clk);
      n_checks++;
      assert (sb.size() == 0) n_pass++;
      else $error("FAIL drain observed %0d pending expected %0d", sb.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
